// File: rtl/moka_rv32i_fetch_buffer.sv
// moka_rv32i_fetch_buffer: RV32I fetch front end with prefetch FIFO and redirect.
// Optional feature macro: MOKA_FETCH_MISALIGN_CHECK_EN (misaligned redirect fault).

module moka_rv32i_fetch_buffer #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget
`ifdef MOKA_FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_fault
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW:0]           DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_M = ~(DATA_WIDTH'(3));

    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [CW-1:0]         r_out_cnt;
    logic [CW-1:0]         r_drop;
    logic [CW-1:0]         r_count;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_tag_wr;
    logic [AW-1:0]         r_tag_rd;
    logic [DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_pc_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_tag_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_last_instr;
    logic [DATA_WIDTH-1:0] r_last_pc;
    logic [DATA_WIDTH-1:0] r_last_pc4;

    logic [CW:0]           w_credit;
    logic [CW-1:0]         w_out_next;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [DATA_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0] w_head_pc4;
    logic                  w_halted;
    logic                  w_fire;
    logic                  w_has_drop;
    logic                  w_push;
    logic                  w_pop;

`ifdef MOKA_FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    // Sticky fault on a misaligned redirect; halts further requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign w_target       = PCTarget;
    assign w_halted       = r_misalign;
    assign misalign_fault = r_misalign;
`else
    assign w_target = PCTarget & ALIGN_M;
    assign w_halted = 1'b0;
`endif

    // Credits: buffered words plus in-flight requests never exceed the FIFO.
    assign w_credit       = {1'b0, r_count} + {1'b0, r_out_cnt};
    assign imem_req_valid = !rst && (w_credit < DEPTH_C) && !w_halted;
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_out_next     = r_out_cnt + CW'(w_fire) - CW'(imem_rsp_valid);

    // Beats owed to a flushed stream are discarded, never buffered.
    assign w_has_drop = (r_drop != '0);
    assign w_push     = imem_rsp_valid && !w_has_drop && !PCSrc;

    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid && instr_ready;
    assign w_head_data = r_data_mem[r_rd_ptr];
    assign w_head_pc   = r_pc_mem[r_rd_ptr];
    assign w_head_pc4  = w_head_pc + STEP;

    assign instruction = instr_valid ? w_head_data : r_last_instr;
    assign pc          = instr_valid ? w_head_pc   : r_last_pc;
    assign PCPlus4     = instr_valid ? w_head_pc4  : r_last_pc4;

    // Control state: fetch pointer, credits, drop counter and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_out_cnt    <= '0;
            r_drop       <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tag_wr     <= '0;
            r_tag_rd     <= '0;
            r_last_instr <= '0;
            r_last_pc    <= '0;
            r_last_pc4   <= '0;
        end else begin
            r_out_cnt <= w_out_next;
            if (w_fire) begin
                r_tag_wr <= r_tag_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
                r_tag_rd <= r_tag_rd + AW'(1);
            end
            if (PCSrc) begin
                r_fetch_pc <= w_target;
                r_drop     <= w_out_next;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + STEP;
                end
                if (imem_rsp_valid && w_has_drop) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            if (w_pop) begin
                r_last_instr <= w_head_data;
                r_last_pc    <= w_head_pc;
                r_last_pc4   <= w_head_pc4;
            end
        end
    end

    // Storage: request-address tags and buffered {instruction, pc} entries.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag_mem[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= imem_rsp_data;
            r_pc_mem[r_wr_ptr]   <= r_tag_mem[r_tag_rd];
        end
    end

    // A kept beat must always find room; otherwise the credit rule broke.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && !w_has_drop && (r_count == FULL_C)));

endmodule

// File: tb/tb_moka_rv32i_fetch_buffer.sv
// tb_moka_rv32i_fetch_buffer: directed bench for the fetch buffer.
// Behavioural memory with configurable latency; popped words logged.

module tb_moka_rv32i_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] PCPlus4;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
`ifdef MOKA_FETCH_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned lat = 1;
    int unsigned cyc = 0;
    int unsigned fire_cnt = 0;

    typedef struct {
        int unsigned due;
        logic [31:0] d;
    } rsp_t;

    rsp_t        mq[$];
    logic [31:0] p_pc[$];
    logic [31:0] p_ins[$];
    logic [31:0] p_p4[$];

    moka_rv32i_fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .pc             (pc),
        .PCPlus4        (PCPlus4),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget)
`ifdef MOKA_FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // In-order memory: a request accepted at cycle c answers lat cycles later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{cyc + lat - 1, word_at(imem_req_addr)});
            end
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq[0].d;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Log every accepted request and every word handed to the core.
    always @(posedge clk) begin
        if (rst) begin
            fire_cnt <= 0;
            p_pc.delete();
            p_ins.delete();
            p_p4.delete();
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                fire_cnt <= fire_cnt + 1;
            end
            if (instr_valid && instr_ready) begin
                p_pc.push_back(pc);
                p_ins.push_back(instruction);
                p_p4.push_back(PCPlus4);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc_at(input int i);
        return (i < p_pc.size()) ? p_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] ins_at(input int i);
        return (i < p_ins.size()) ? p_ins[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] p4_at(input int i);
        return (i < p_p4.size()) ? p_p4[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        PCSrc          = 1'b0;
        PCTarget       = '0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_instruction", instruction, 32'd0);
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_pcplus4", PCPlus4, 32'd0);
`ifdef MOKA_FETCH_MISALIGN_CHECK_EN
        check_eq("rst_misalign", 32'(misalign_fault), 32'd0);
`endif
        rst = 1'b0;
    endtask

    task automatic wait_pops(input int unsigned n, input string tag);
        int unsigned k = 0;
        while (p_pc.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(p_pc.size() >= n), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] t);
        PCSrc    = 1'b1;
        PCTarget = t;
        @(negedge clk);
        PCSrc    = 1'b0;
    endtask

    initial begin
        int unsigned k;

        // 1: sequential fetch from reset, latency 1.
        lat = 1;
        do_reset();
        wait_pops(4, "t1_pops");
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_pc", pc_at(i), 32'(4 * i));
            check_eq("t1_ins", ins_at(i), word_at(32'(4 * i)));
        end
        check_eq("t1_pc4", p4_at(0), 32'd4);

        // 2: core stalled, fetch capped by FIFO depth, nothing lost.
        do_reset();
        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t2_fires", 32'(fire_cnt), 32'd2);
        check_eq("t2_valid", 32'(instr_valid), 32'd1);
        check_eq("t2_pc", pc, 32'd0);
        check_eq("t2_ins", instruction, word_at(32'd0));
        check_eq("t2_pc4", PCPlus4, 32'd4);
        instr_ready = 1'b1;
        wait_pops(4, "t2_pops");
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_seq", pc_at(i), 32'(4 * i));
        end

        // 3: redirect with two requests in flight, latency 3.
        lat = 3;
        do_reset();
        k = 0;
        while (fire_cnt < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("t3_inflight", 32'(fire_cnt), 32'd2);
        check_eq("t3_credit_stop", 32'(imem_req_valid), 32'd0);
        redirect(32'h100);
        check_eq("t3_flush", 32'(instr_valid), 32'd0);
        wait_pops(2, "t3_pops");
        check_eq("t3_pc0", pc_at(0), 32'h100);
        check_eq("t3_ins0", ins_at(0), word_at(32'h100));
        check_eq("t3_pc1", pc_at(1), 32'h104);

        // 4: redirect in the same cycle as a fire and a pop.
        lat = 1;
        do_reset();
        k = 0;
        while (!(instr_valid && imem_req_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("t4_setup", 32'(instr_valid && imem_req_valid), 32'd1);
        k = p_pc.size();
        redirect(32'h100);
        check_eq("t4_flush", 32'(instr_valid), 32'd0);
        wait_pops(k + 3, "t4_pops");
        check_eq("t4_pc_a", pc_at(k + 1), 32'h100);
        check_eq("t4_ins_a", ins_at(k + 1), word_at(32'h100));
        check_eq("t4_pc_b", pc_at(k + 2), 32'h104);

        // 5: fetch address wraps past the top of the address space.
        do_reset();
        redirect(32'hFFFF_FFF8);
        wait_pops(4, "t5_pops");
        check_eq("t5_pc0", pc_at(0), 32'hFFFF_FFF8);
        check_eq("t5_pc4_0", p4_at(0), 32'hFFFF_FFFC);
        check_eq("t5_pc1", pc_at(1), 32'hFFFF_FFFC);
        check_eq("t5_pc4_1", p4_at(1), 32'h0);
        check_eq("t5_pc2", pc_at(2), 32'h0);
        check_eq("t5_ins2", ins_at(2), word_at(32'h0));
        check_eq("t5_pc3", pc_at(3), 32'h4);

        // 6: misaligned redirect target.
        do_reset();
        redirect(32'h102);
`ifdef MOKA_FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("t6_fault", 32'(misalign_fault), 32'd1);
            check_eq("t6_halt", 32'(imem_req_valid), 32'd0);
            check_eq("t6_novalid", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        do_reset();
        @(negedge clk);
        check_eq("t6_restart", pc_at(0) == 32'hDEAD_DEAD ?
                 32'(fire_cnt >= 1) : 32'd1, 32'd1);
`else
        wait_pops(2, "t6_pops");
        check_eq("t6_pc0", pc_at(0), 32'h100);
        check_eq("t6_ins0", ins_at(0), word_at(32'h100));
        check_eq("t6_pc1", pc_at(1), 32'h104);
`endif

        // 7: reset with responses in flight; restart is clean.
        lat = 3;
        do_reset();
        repeat (3) @(negedge clk);
        do_reset();
        wait_pops(2, "t7_pops");
        check_eq("t7_pc0", pc_at(0), 32'h0);
        check_eq("t7_ins0", ins_at(0), word_at(32'h0));
        check_eq("t7_pc1", pc_at(1), 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
